uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Oversampling receive sequencer for the 8N1 serial input path. Runs from the
//  fast system clock: synchronises rx, times start/data/stop sampling with an
//  internal bit-period counter, checks framing and presents each byte on a
//  valid/ready interface. Reports framing errors and overruns to the consumer.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit (50 MHz / 9600 baud); legal range >= 4
//  (H = CLKS_PER_BIT/2, integer division; used below)
// PORTS
//  clk         in   1  system clock; all state on posedge
//  rst         in   1  reset, asynchronous, active-high
//  rx          in   1  serial line, idle high, LSB first, async to clk
//  data_out    out  8  received byte, stable while data_valid=1
//  data_valid  out  1  byte held for consumer
//  data_ready  in   1  consumer accepts byte when data_valid & data_ready
//  frame_err   out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun     out  1  1-cycle pulse: new byte arrived while one still held
//  busy        out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (async): FSM=IDLE, counters=0, shift reg=0, data_out=0x00,
//   data_valid=0, frame_err=0, overrun=0, busy=0, both sync flops=1.
//  rx -> 2-flop synchroniser -> rx_s; FSM uses rx_s only.
//  clk_cnt: $clog2(CLKS_PER_BIT) bits, cleared on every state change; bit_idx: 3 bits.
//  IDLE:  rx_s==0 -> START, clk_cnt=0.
//  START: at clk_cnt==H-1: rx_s==0 -> DATA (bit_idx=0); rx_s==1 -> IDLE (glitch,
//         no flags).
//  DATA:  at clk_cnt==CLKS_PER_BIT-1: shift rx_s into bit bit_idx, clk_cnt=0;
//         after bit_idx==7 -> STOP, else bit_idx+1.
//  STOP:  at clk_cnt==CLKS_PER_BIT-1: rx_s==1 -> deliver byte, IDLE;
//         rx_s==0 -> frame_err pulse, byte dropped, -> BREAK.
//  BREAK: wait for rx_s==1 -> IDLE (no new start detected while line held low).
//  Timing: rx pin falls before edge k -> START entered at edge k+3; bit i
//   sampled at edge k+3+H+(i+1)*CLKS_PER_BIT; stop sampled at edge
//   k+3+H+9*CLKS_PER_BIT; data_valid=1 from that edge.
//  Delivery at stop sample:
//   - data_valid==0: load data_out, data_valid<=1.
//   - data_valid==1 & data_ready==1 same cycle: old byte consumed, new byte
//     loaded, data_valid stays 1, no overrun.
//   - data_valid==1 & data_ready==0: new byte dropped, data_out unchanged,
//     overrun pulses 1 cycle.
//  Otherwise data_valid clears on the edge where data_valid & data_ready.
//  data_ready while data_valid==0 is ignored.
//  frame_err and overrun are never both set in the same cycle.
//  Reset mid-frame: partial byte discarded, no flags, held byte discarded.
// TESTING (CLKS_PER_BIT=16, H=8, data_ready=1 unless stated)
//  1 rx sends 0x55 8N1 -> data_out=0x55, data_valid high exactly 1 cycle,
//    rising at edge k+3+8+144; frame_err=overrun=0.
//  2 rx low for 4 clks then high -> START aborts at edge k+11, no data_valid,
//    busy returns 0.
//  3 frame 0xA3 with stop bit 0, rx held low 40 clks -> frame_err 1 pulse,
//    no data_valid, FSM in BREAK until rx high, next 0x3C received correctly.
//  4 data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses
//    once at 2nd stop sample; raise ready -> valid drops, data_out 0x11 read.
//  5 back-to-back 0x00,0xFF,0x81 no idle gap -> three bytes in order, no flags.
//  6 assert rst during bit 4 of 0xF0, release, send 0x0F -> only 0x0F
//    delivered; all outputs 0 while rst high.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// 8N1 oversampling UART receive sequencer with valid/ready byte delivery.
// Flags framing errors and overruns as single-cycle pulses.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] clk_cnt, clk_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [7:0]    data_out_d;
  logic          data_valid_d, frame_err_d, overrun_d;
  logic          rx_meta, rx_sync, rx_s;

  // Two-flop synchroniser; rx_s retimes once more so a start is taken three
  // edges after the pin falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_s    <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      clk_cnt    <= clk_cnt_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      busy       <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d      = state;
    clk_cnt_d    = clk_cnt;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    data_out_d   = data_out;
    data_valid_d = data_valid;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    if (data_valid && data_ready) data_valid_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_BIT) begin
          clk_cnt_d        = '0;
          shreg_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_BIT) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            // A held byte being consumed this cycle frees the slot.
            if (!data_valid || data_ready) begin
              data_out_d   = shreg;
              data_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (CLKS_PER_BIT=16): table of frames plus
// hand-written timing, glitch, overrun, back-to-back and reset sequences.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_ferr = 0, n_ovr = 0, n_acc = 0, n_vcyc = 0, n_both = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err && overrun) n_both++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (data_valid) begin
        n_vcyc++;
        if (!valid_prev) rise_cyc = cyc;
      end
      if (data_valid && data_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", 32'(data_out), 32'(exp_b));
        end
      end
      valid_prev = data_valid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  // Drives the first nbits bit periods of an 8N1 frame; call at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits, output int k);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    k = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, a0, f0, o0, v0;
    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h81, 1'b1, 1, 0};
    vecs[4] = '{8'hA3, 1'b0, 0, 1};
    vecs[5] = '{8'h3C, 1'b1, 1, 0};

    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Single byte: exact rise edge and one-cycle valid.
    a0 = n_acc; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 10, k);
    idle(10);
    check("t1_rise_edge", 32'(rise_cyc), 32'(k + 3 + 8 + 144));
    check("t1_valid_cycles", 32'(n_vcyc - v0), 32'd1);
    check("t1_accepts", 32'(n_acc - a0), 32'd1);
    check("t1_flags", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

    // Start glitch: 4 clocks low.
    a0 = n_acc; f0 = n_ferr;
    k = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    while (cyc < k + 10) @(negedge clk);
    check("t2_busy_in_start", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_busy_after_abort", 32'(busy), 32'h0);
    idle(20);
    check("t2_no_byte", 32'(n_acc - a0), 32'd0);
    check("t2_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Table of isolated frames, including a framing error held as a break.
    for (int i = 0; i < 6; i++) begin
      a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
      if (vecs[i].exp_bytes != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 10, k);
      if (!vecs[i].stop) begin
        repeat (40) @(negedge clk);
        check($sformatf("vec%0d_break_busy", i), 32'(busy), 32'h1);
      end
      idle(20);
      check($sformatf("vec%0d_bytes", i), 32'(n_acc - a0), 32'(vecs[i].exp_bytes));
      check($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_ovr", i), 32'(n_ovr - o0), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'h0);
    end

    // Overrun: consumer stalled across two frames.
    data_ready = 1'b0;
    f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 10, k);
    send_frame(8'h22, 1'b1, 10, k);
    idle(5);
    check("t4_ovr_count", 32'(n_ovr - o0), 32'd1);
    check("t4_no_ferr", 32'(n_ferr - f0), 32'd0);
    check("t4_data_held", 32'(data_out), 32'h11);
    check("t4_valid_held", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_valid_dropped", 32'(data_valid), 32'h0);

    // Back-to-back frames with no idle gap.
    a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1, 10, k);
    send_frame(8'hFF, 1'b1, 10, k);
    send_frame(8'h81, 1'b1, 10, k);
    idle(10);
    check("t5_bytes", 32'(n_acc - a0), 32'd3);
    check("t5_flags", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

    // Reset mid-frame with a byte already held.
    data_ready = 1'b0;
    send_frame(8'hAA, 1'b1, 10, k);
    idle(5);
    check("t6_held_before_rst", 32'(data_valid), 32'h1);
    send_frame(8'hF0, 1'b1, 5, k);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_data_out", 32'(data_out), 32'h00);
    check("t6_rst_valid", 32'(data_valid), 32'h0);
    check("t6_rst_flags", 32'({frame_err, overrun}), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    data_ready = 1'b1;
    idle(20);
    a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 10, k);
    idle(20);
    check("t6_bytes", 32'(n_acc - a0), 32'd1);
    check("t6_flags", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("flags_exclusive", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
